sign_mag_to_twos: RTL and testbench



---
 rtl/sign_mag_to_twos.sv | 37 +++
 tb/tb_sign_mag_to_twos.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sign_mag_to_twos.sv
// Sign-magnitude to two's-complement converter for LDPC message words.
// One registered stage with a valid qualifier: one-cycle latency, full throughput.
module sign_mag_to_twos #(
    parameter int DATA_WIDTH = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic        [DATA_WIDTH-1:0] inp,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out
);

    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    logic                  sign;
    logic [DATA_WIDTH-1:0] mag;
    logic [DATA_WIDTH-1:0] conv;

    // Negative zero falls out naturally: ~0 + 1 wraps to 0.
    always_comb begin
        sign = inp[DATA_WIDTH-1];
        mag  = {1'b0, inp[DATA_WIDTH-2:0]};
        conv = sign ? (~mag + ONE) : mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out       <= conv;
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_sign_mag_to_twos.sv
// Self-checking bench for sign_mag_to_twos (DATA_WIDTH = 6).
// Expected values come from integer negation of the magnitude, not from the RTL.
module tb_sign_mag_to_twos;

    localparam int DW = 6;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic        [DW-1:0] inp;
    logic                 out_valid;
    logic signed [DW-1:0] out;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sign_mag_to_twos #(.DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .inp      (inp),
        .out_valid(out_valid),
        .out      (out)
    );

    always #5 clk = ~clk;

    // Signed value of a sign-magnitude word, reduced modulo 2^DW.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] w);
        int m;
        int v;
        m = int'(w) % (1 << (DW - 1));
        v = (int'(w) >= (1 << (DW - 1))) ? -m : m;
        return DW'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; inp = 6'b100101;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (out !== 6'b000000) $display("FAIL reset_out cycle %0d: got %b want 000000", i, out);
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== 1'b0) $display("FAIL reset_valid cycle %0d: got %b want 0", i, out_valid);
            else pass_cnt++;
        end
        rst = 1'b0;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL reset_first_valid: got %b want 1", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out !== 6'b111011) $display("FAIL reset_first_out: got %b want 111011", out);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [DW-1:0] vecs [6];
        logic [DW-1:0] want [6];
        vecs = '{6'b000101, 6'b100101, 6'b011111, 6'b111111, 6'b100000, 6'b000000};
        want = '{6'b000101, 6'b111011, 6'b011111, 6'b100001, 6'b000000, 6'b000000};
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; inp = vecs[i];
            tick();
            total_cnt++;
            if (out !== want[i]) $display("FAIL directed_out inp=%b: got %b want %b", vecs[i], out, want[i]);
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== 1'b1) $display("FAIL directed_valid inp=%b: got %b want 1", vecs[i], out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_sweep();
        logic [DW-1:0] prev;
        in_valid = 1'b1; inp = '0;
        tick();
        prev = model('0);
        for (int c = 1; c < 64; c++) begin
            inp = DW'(c);
            #1;
            // Output must not move before the clock edge.
            total_cnt++;
            if (out !== prev) $display("FAIL sweep_hold inp=%b: got %b want %b", inp, out, prev);
            else pass_cnt++;
            tick();
            prev = model(DW'(c));
            total_cnt++;
            if (out !== prev) $display("FAIL sweep_out inp=%b: got %b want %b", inp, out, prev);
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== 1'b1) $display("FAIL sweep_valid inp=%b: got %b want 1", inp, out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_valid_gaps();
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            in_valid = pat[i]; inp = DW'($urandom);
            tick();
            total_cnt++;
            if (out_valid !== pat[i]) $display("FAIL gap_valid step %0d: got %b want %b", i, out_valid, pat[i]);
            else pass_cnt++;
            total_cnt++;
            if (out !== model(inp)) $display("FAIL gap_out step %0d inp=%b: got %b want %b", i, inp, out, model(inp));
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset();
        in_valid = 1'b1; inp = 6'b110011;
        tick();
        rst = 1'b1; inp = 6'b101010;
        tick();
        total_cnt++;
        if (out !== 6'b000000) $display("FAIL midrst_out: got %b want 000000", out);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", out_valid);
        else pass_cnt++;
        rst = 1'b0; inp = 6'b001001;
        tick();
        total_cnt++;
        if (out !== 6'b001001) $display("FAIL midrst_resume_out: got %b want 001001", out);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL midrst_resume_valid: got %b want 1", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [DW-1:0] exp_out;
        logic          exp_vld;
        for (int i = 0; i < 300; i++) begin
            rst      = ($urandom_range(15) == 0);
            in_valid = 1'($urandom);
            inp      = DW'($urandom);
            exp_out  = rst ? '0 : model(inp);
            exp_vld  = rst ? 1'b0 : in_valid;
            tick();
            total_cnt++;
            if (out !== exp_out) $display("FAIL rand_out i=%0d inp=%b rst=%b: got %b want %b", i, inp, rst, out, exp_out);
            else pass_cnt++;
            total_cnt++;
            if (out_valid !== exp_vld) $display("FAIL rand_valid i=%0d: got %b want %b", i, out_valid, exp_vld);
            else pass_cnt++;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; inp = '0;
        #2;
        test_reset();
        test_directed();
        test_sweep();
        test_valid_gaps();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
